// File: rtl/wbufifo_lvl_if.sv
`default_nettype none
// ============================================================================
// wbufifo_lvl_if : push/pop handshake and status bundle for wbufifo_lvl
// Rev 1.0
// ============================================================================
interface wbufifo_lvl_if #(
    parameter int BW     = 36,
    parameter int LGFLEN = 10
);
    logic              i_wr;
    logic [BW-1:0]     i_data;
    logic              i_rd;
    logic              i_clr_err;
    logic [BW-1:0]     o_data;
    logic              o_empty_n;
    logic              o_valid;
    logic              o_full;
    logic [LGFLEN:0]   o_fill;
    logic              o_almost_full;
    logic              o_almost_empty;
    logic              o_err;
    logic              o_ovfl;
    logic              o_unfl;

    modport master (
        output i_wr, i_data, i_rd, i_clr_err,
        input  o_data, o_empty_n, o_valid, o_full, o_fill,
               o_almost_full, o_almost_empty, o_err, o_ovfl, o_unfl
    );

    modport slave (
        input  i_wr, i_data, i_rd, i_clr_err,
        output o_data, o_empty_n, o_valid, o_full, o_fill,
               o_almost_full, o_almost_empty, o_err, o_ovfl, o_unfl
    );
endinterface
`default_nettype wire

// File: rtl/wbufifo_lvl.sv
`default_nettype none
// ============================================================================
// wbufifo_lvl : single-clock codeword FIFO, FWFT/registered read, level flags
// Rev 1.0
// ============================================================================
module wbufifo_lvl #(
    parameter int BW       = 36,
    parameter int LGFLEN   = 10,
    parameter int OPT_FWFT = 1,
    parameter int AF_LEVEL = 960,
    parameter int AE_LEVEL = 64
) (
    input  wire logic    i_clk,
    input  wire logic    i_reset_n,
    wbufifo_lvl_if.slave bus
);
    localparam int              FLEN     = 1 << LGFLEN;
    localparam logic [LGFLEN:0] c_FLEN   = (LGFLEN+1)'(FLEN);
    localparam logic [LGFLEN:0] c_AF_LVL = (LGFLEN+1)'(AF_LEVEL);
    localparam logic [LGFLEN:0] c_AE_LVL = (LGFLEN+1)'(AE_LEVEL);

    logic [BW-1:0]   mem [FLEN];
    logic [BW-1:0]   data_q;
    logic [LGFLEN:0] wr_ptr_q, wr_ptr_d;
    logic [LGFLEN:0] rd_ptr_q, rd_ptr_d;
    logic [LGFLEN:0] fill_q, fill_d;
    logic [LGFLEN:0] w_fill_pop;
    logic            empty_n_q, empty_n_d;
    logic            valid_q, valid_d;
    logic            full_q, full_d;
    logic            af_q, af_d;
    logic            ae_q, ae_d;
    logic            err_q, err_d;
    logic            ovfl_q, ovfl_d;
    logic            unfl_q, unfl_d;
    logic            w_push, w_pop, w_ovf, w_unf;

    always_comb begin
        w_pop      = bus.i_rd && empty_n_q;
        w_push     = bus.i_wr && (!full_q || w_pop);
        w_ovf      = bus.i_wr && full_q && !w_pop;
        w_unf      = bus.i_rd && !empty_n_q;
        w_fill_pop = fill_q - {{LGFLEN{1'b0}}, w_pop};
        fill_d     = w_fill_pop + {{LGFLEN{1'b0}}, w_push};
        wr_ptr_d   = wr_ptr_q + {{LGFLEN{1'b0}}, w_push};
        rd_ptr_d   = rd_ptr_q + {{LGFLEN{1'b0}}, w_pop};
        full_d     = (fill_d == c_FLEN);
        af_d       = (fill_d >= c_AF_LVL);
        ae_d       = (fill_d <= c_AE_LVL);
        err_d      = w_ovf || w_unf;
        // A fresh error outranks a clear arriving in the same cycle
        ovfl_d     = w_ovf || (ovfl_q && !bus.i_clr_err);
        unfl_d     = w_unf || (unfl_q && !bus.i_clr_err);
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            mem[wr_ptr_q[LGFLEN-1:0]] <= bus.i_data;
        end
    end

    generate
        if (OPT_FWFT != 0) begin : g_fwft
            // The head is only showable once it sat in RAM before this edge,
            // so a word written into an emptied FIFO costs one bubble cycle.
            assign empty_n_d = (w_fill_pop != '0);
            assign valid_d   = empty_n_d;
            always_ff @(posedge i_clk) begin
                data_q <= mem[rd_ptr_d[LGFLEN-1:0]];
            end
        end else begin : g_reg
            assign empty_n_d = (fill_d != '0);
            assign valid_d   = w_pop;
            always_ff @(posedge i_clk) begin
                if (w_pop) begin
                    data_q <= mem[rd_ptr_q[LGFLEN-1:0]];
                end
            end
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            fill_q    <= '0;
            empty_n_q <= 1'b0;
            valid_q   <= 1'b0;
            full_q    <= 1'b0;
            af_q      <= (AF_LEVEL == 0);
            ae_q      <= 1'b1;
            err_q     <= 1'b0;
            ovfl_q    <= 1'b0;
            unfl_q    <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            fill_q    <= fill_d;
            empty_n_q <= empty_n_d;
            valid_q   <= valid_d;
            full_q    <= full_d;
            af_q      <= af_d;
            ae_q      <= ae_d;
            err_q     <= err_d;
            ovfl_q    <= ovfl_d;
            unfl_q    <= unfl_d;
        end
    end

    assign bus.o_data         = data_q;
    assign bus.o_empty_n      = empty_n_q;
    assign bus.o_valid        = valid_q;
    assign bus.o_full         = full_q;
    assign bus.o_fill         = fill_q;
    assign bus.o_almost_full  = af_q;
    assign bus.o_almost_empty = ae_q;
    assign bus.o_err          = err_q;
    assign bus.o_ovfl         = ovfl_q;
    assign bus.o_unfl         = unfl_q;
endmodule
`default_nettype wire

// File: tb/tb_wbufifo_lvl.sv
`default_nettype none
// ============================================================================
// tb_wbufifo_lvl : directed checks of wbufifo_lvl in FWFT and registered modes
// Rev 1.0
// ============================================================================
module tb_wbufifo_lvl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vecs = 0;
    int   errs = 0;
    logic [7:0] q[$];

    always #5 clk = ~clk;

    wbufifo_lvl_if #(.BW(8), .LGFLEN(2)) ifa ();
    wbufifo_lvl_if #(.BW(8), .LGFLEN(2)) ifb ();
    wbufifo_lvl_if #(.BW(8), .LGFLEN(3)) ifc ();

    wbufifo_lvl #(.BW(8), .LGFLEN(2), .OPT_FWFT(1), .AF_LEVEL(3), .AE_LEVEL(1))
        dut_a (.i_clk(clk), .i_reset_n(rst_n), .bus(ifa));
    wbufifo_lvl #(.BW(8), .LGFLEN(2), .OPT_FWFT(0), .AF_LEVEL(4), .AE_LEVEL(0))
        dut_b (.i_clk(clk), .i_reset_n(rst_n), .bus(ifb));
    wbufifo_lvl #(.BW(8), .LGFLEN(3), .OPT_FWFT(1), .AF_LEVEL(6), .AE_LEVEL(2))
        dut_c (.i_clk(clk), .i_reset_n(rst_n), .bus(ifc));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        ifa.i_wr = 0; ifa.i_rd = 0; ifa.i_data = 0; ifa.i_clr_err = 0;
        ifb.i_wr = 0; ifb.i_rd = 0; ifb.i_data = 0; ifb.i_clr_err = 0;
        ifc.i_wr = 0; ifc.i_rd = 0; ifc.i_data = 0; ifc.i_clr_err = 0;
        rst_n = 0;
        tick; tick;
        vecs++; if (ifa.o_fill !== 3'd0 || ifa.o_empty_n !== 1'b0 || ifa.o_almost_empty !== 1'b1) begin
            errs++; $display("FAIL rst_a fill=%0d empty_n=%b ae=%b exp 0/0/1", ifa.o_fill, ifa.o_empty_n, ifa.o_almost_empty); end
        vecs++; if (ifa.o_full !== 1'b0 || ifa.o_almost_full !== 1'b0 || ifa.o_ovfl !== 1'b0 || ifa.o_unfl !== 1'b0 || ifa.o_valid !== 1'b0) begin
            errs++; $display("FAIL rst_a_flags full=%b af=%b ovfl=%b unfl=%b valid=%b exp all 0", ifa.o_full, ifa.o_almost_full, ifa.o_ovfl, ifa.o_unfl, ifa.o_valid); end
        vecs++; if (ifb.o_fill !== 3'd0 || ifb.o_empty_n !== 1'b0 || ifb.o_valid !== 1'b0 || ifb.o_almost_empty !== 1'b1) begin
            errs++; $display("FAIL rst_b fill=%0d empty_n=%b valid=%b ae=%b exp 0/0/0/1", ifb.o_fill, ifb.o_empty_n, ifb.o_valid, ifb.o_almost_empty); end
        vecs++; if (ifc.o_fill !== 4'd0 || ifc.o_empty_n !== 1'b0 || ifc.o_err !== 1'b0) begin
            errs++; $display("FAIL rst_c fill=%0d empty_n=%b err=%b exp 0/0/0", ifc.o_fill, ifc.o_empty_n, ifc.o_err); end
        rst_n = 1;
    endtask

    // Fill to capacity, watch level flags move on each edge, overflow, drain
    task automatic test_fill_overflow;
        for (int i = 1; i <= 4; i++) begin
            ifa.i_wr = 1; ifa.i_data = 8'(i);
            tick;
            vecs++; if (ifa.o_fill !== 3'(i) || ifa.o_almost_empty !== (i <= 1) || ifa.o_almost_full !== (i >= 3) || ifa.o_full !== (i == 4)) begin
                errs++; $display("FAIL fill_step%0d fill=%0d ae=%b af=%b full=%b", i, ifa.o_fill, ifa.o_almost_empty, ifa.o_almost_full, ifa.o_full); end
        end
        ifa.i_data = 8'h05;
        tick;
        ifa.i_wr = 0;
        vecs++; if (ifa.o_err !== 1'b1 || ifa.o_ovfl !== 1'b1 || ifa.o_fill !== 3'd4) begin
            errs++; $display("FAIL ovfl err=%b ovfl=%b fill=%0d exp 1/1/4", ifa.o_err, ifa.o_ovfl, ifa.o_fill); end
        tick;
        vecs++; if (ifa.o_err !== 1'b0 || ifa.o_ovfl !== 1'b1) begin
            errs++; $display("FAIL ovfl_pulse err=%b ovfl=%b exp 0/1", ifa.o_err, ifa.o_ovfl); end
        for (int i = 1; i <= 4; i++) begin
            vecs++; if (ifa.o_empty_n !== 1'b1 || ifa.o_data !== 8'(i)) begin
                errs++; $display("FAIL pop%0d data=%h empty_n=%b exp %h/1", i, ifa.o_data, ifa.o_empty_n, 8'(i)); end
            ifa.i_rd = 1;
            tick;
            vecs++; if (ifa.o_fill !== 3'(4 - i)) begin
                errs++; $display("FAIL pop_fill%0d fill=%0d exp %0d", i, ifa.o_fill, 4 - i); end
        end
        ifa.i_rd = 0;
        vecs++; if (ifa.o_empty_n !== 1'b0 || ifa.o_err !== 1'b0) begin
            errs++; $display("FAIL drained empty_n=%b err=%b exp 0/0", ifa.o_empty_n, ifa.o_err); end
    endtask

    task automatic test_full_rw;
        logic [7:0] exp_d [4];
        exp_d[0] = 8'h12; exp_d[1] = 8'h13; exp_d[2] = 8'h14; exp_d[3] = 8'h09;
        for (int i = 0; i < 4; i++) begin
            ifa.i_wr = 1; ifa.i_data = 8'h11 + 8'(i);
            tick;
        end
        ifa.i_data = 8'h09; ifa.i_rd = 1;
        tick;
        ifa.i_wr = 0; ifa.i_rd = 0;
        vecs++; if (ifa.o_err !== 1'b0 || ifa.o_fill !== 3'd4 || ifa.o_full !== 1'b1) begin
            errs++; $display("FAIL full_rw err=%b fill=%0d full=%b exp 0/4/1", ifa.o_err, ifa.o_fill, ifa.o_full); end
        for (int i = 0; i < 4; i++) begin
            vecs++; if (ifa.o_empty_n !== 1'b1 || ifa.o_data !== exp_d[i]) begin
                errs++; $display("FAIL full_rw_drain%0d data=%h exp %h", i, ifa.o_data, exp_d[i]); end
            ifa.i_rd = 1;
            tick;
        end
        ifa.i_rd = 0;
        vecs++; if (ifa.o_fill !== 3'd0 || ifa.o_empty_n !== 1'b0) begin
            errs++; $display("FAIL full_rw_end fill=%0d empty_n=%b exp 0/0", ifa.o_fill, ifa.o_empty_n); end
    endtask

    task automatic test_regread;
        ifb.i_wr = 1; ifb.i_data = 8'h0A;
        tick;
        vecs++; if (ifb.o_fill !== 3'd1 || ifb.o_empty_n !== 1'b1 || ifb.o_valid !== 1'b0) begin
            errs++; $display("FAIL rr_push fill=%0d empty_n=%b valid=%b exp 1/1/0", ifb.o_fill, ifb.o_empty_n, ifb.o_valid); end
        ifb.i_data = 8'h0B;
        tick;
        ifb.i_wr = 0; ifb.i_rd = 1;
        tick;
        ifb.i_rd = 0;
        vecs++; if (ifb.o_valid !== 1'b1 || ifb.o_data !== 8'h0A || ifb.o_fill !== 3'd1) begin
            errs++; $display("FAIL rr_pop1 valid=%b data=%h fill=%0d exp 1/0a/1", ifb.o_valid, ifb.o_data, ifb.o_fill); end
        tick;
        vecs++; if (ifb.o_valid !== 1'b0) begin
            errs++; $display("FAIL rr_valid_drop valid=%b exp 0", ifb.o_valid); end
        ifb.i_rd = 1;
        tick;
        ifb.i_rd = 0;
        vecs++; if (ifb.o_valid !== 1'b1 || ifb.o_data !== 8'h0B || ifb.o_empty_n !== 1'b0) begin
            errs++; $display("FAIL rr_pop2 valid=%b data=%h empty_n=%b exp 1/0b/0", ifb.o_valid, ifb.o_data, ifb.o_empty_n); end
        ifb.i_rd = 1;
        tick;
        ifb.i_rd = 0;
        vecs++; if (ifb.o_err !== 1'b1 || ifb.o_unfl !== 1'b1 || ifb.o_valid !== 1'b0 || ifb.o_ovfl !== 1'b0) begin
            errs++; $display("FAIL rr_unfl err=%b unfl=%b valid=%b ovfl=%b exp 1/1/0/0", ifb.o_err, ifb.o_unfl, ifb.o_valid, ifb.o_ovfl); end
        tick;
        vecs++; if (ifb.o_err !== 1'b0 || ifb.o_unfl !== 1'b1) begin
            errs++; $display("FAIL rr_unfl_sticky err=%b unfl=%b exp 0/1", ifb.o_err, ifb.o_unfl); end
    endtask

    // Random interleaved traffic against a queue model; pointers wrap many times
    task automatic test_wrap;
        logic       rd, wr;
        logic [7:0] d;
        q.delete();
        for (int c = 0; c < 64; c++) begin
            vecs++; if (ifc.o_fill !== 4'(q.size()) || ifc.o_full !== (q.size() == 8) || ifc.o_err !== 1'b0) begin
                errs++; $display("FAIL wrap_fill cyc%0d fill=%0d full=%b err=%b exp %0d", c, ifc.o_fill, ifc.o_full, ifc.o_err, q.size()); end
            vecs++;
            if (ifc.o_empty_n) begin
                if (q.size() == 0) begin
                    errs++; $display("FAIL wrap_head cyc%0d empty_n=1 exp model empty", c);
                end else if (ifc.o_data !== q[0]) begin
                    errs++; $display("FAIL wrap_head cyc%0d data=%h exp %h", c, ifc.o_data, q[0]);
                end
            end else if (q.size() >= 2) begin
                errs++; $display("FAIL wrap_stall cyc%0d empty_n=0 exp 1 (model holds %0d)", c, q.size());
            end
            rd = ifc.o_empty_n && ($urandom_range(3) != 0);
            wr = ($urandom_range(7) != 0) && ((q.size() < 8) || rd);
            d  = 8'($urandom_range(255));
            ifc.i_rd = rd; ifc.i_wr = wr; ifc.i_data = d;
            tick;
            if (rd) void'(q.pop_front());
            if (wr) q.push_back(d);
        end
        ifc.i_rd = 0; ifc.i_wr = 0;
    endtask

    task automatic test_clr_err;
        ifa.i_clr_err = 1;
        tick;
        ifa.i_clr_err = 0;
        vecs++; if (ifa.o_ovfl !== 1'b0) begin
            errs++; $display("FAIL clr_idle ovfl=%b exp 0", ifa.o_ovfl); end
        for (int i = 0; i < 4; i++) begin
            ifa.i_wr = 1; ifa.i_data = 8'h21 + 8'(i);
            tick;
        end
        ifa.i_data = 8'h77; ifa.i_clr_err = 1;
        tick;
        ifa.i_wr = 0;
        vecs++; if (ifa.o_ovfl !== 1'b1 || ifa.o_err !== 1'b1 || ifa.o_fill !== 3'd4) begin
            errs++; $display("FAIL clr_vs_set ovfl=%b err=%b fill=%0d exp 1/1/4", ifa.o_ovfl, ifa.o_err, ifa.o_fill); end
        tick;
        ifa.i_clr_err = 0;
        vecs++; if (ifa.o_ovfl !== 1'b0 || ifa.o_err !== 1'b0) begin
            errs++; $display("FAIL clr_after ovfl=%b err=%b exp 0/0", ifa.o_ovfl, ifa.o_err); end
    endtask

    task automatic test_reset_mid;
        vecs++; if (ifa.o_data !== 8'h21) begin
            errs++; $display("FAIL mid_head data=%h exp 21", ifa.o_data); end
        ifa.i_rd = 1;
        tick;
        ifa.i_rd = 0;
        vecs++; if (ifa.o_fill !== 3'd3) begin
            errs++; $display("FAIL mid_fill fill=%0d exp 3", ifa.o_fill); end
        rst_n = 0;
        tick;
        rst_n = 1;
        vecs++; if (ifa.o_fill !== 3'd0 || ifa.o_empty_n !== 1'b0 || ifa.o_full !== 1'b0 || ifa.o_almost_empty !== 1'b1) begin
            errs++; $display("FAIL mid_rst fill=%0d empty_n=%b full=%b ae=%b exp 0/0/0/1", ifa.o_fill, ifa.o_empty_n, ifa.o_full, ifa.o_almost_empty); end
        ifa.i_wr = 1; ifa.i_data = 8'h5A;
        tick;
        ifa.i_wr = 0;
        vecs++; if (ifa.o_empty_n !== 1'b0 || ifa.o_fill !== 3'd1) begin
            errs++; $display("FAIL post_rst_latency empty_n=%b fill=%0d exp 0/1", ifa.o_empty_n, ifa.o_fill); end
        tick;
        vecs++; if (ifa.o_empty_n !== 1'b1 || ifa.o_data !== 8'h5A) begin
            errs++; $display("FAIL post_rst_head empty_n=%b data=%h exp 1/5a", ifa.o_empty_n, ifa.o_data); end
    endtask

    initial begin
        test_reset;
        test_fill_overflow;
        test_full_rw;
        test_regread;
        test_wrap;
        test_clr_err;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end
endmodule
`default_nettype wire
